cv32e40p_clock_gate_ctrl: RTL and testbench



---
 rtl/cv32e40p_clock_gate_ctrl.sv | 109 ++++++++++
 tb/tb_cv32e40p_clock_gate_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Core clock-gate enable controller: sleep handshake, idle drain,
// gated hold, wake settle window and gated-cycle statistics.
module cv32e40p_clock_gate_ctrl #(
   parameter int unsigned IDLE_CYCLES = 4,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned STAT_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sleep_req_i,
   input  logic              core_busy_i,
   input  logic              wake_i,
   input  logic              force_en_i,
   output logic              clk_en_o,
   output logic              sleep_ack_o,
   output logic              sleeping_o,
   output logic              wake_done_o,
   output logic [STAT_W-1:0] gated_cnt_o
);

   localparam int unsigned MAXC =
      (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      GATED,
      WAKE
   } state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                en_q, en_d;
   logic                wd_q, wd_d;
   logic [STAT_W-1:0]   gcnt_q, gcnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (sleep_req_i && !wake_i) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            if (wake_i || !sleep_req_i) begin
               state_d = RUN;
            end else if (core_busy_i) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(IDLE_CYCLES - 1)) begin
               state_d = GATED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GATED: begin
            if (wake_i || !sleep_req_i) begin
               state_d = WAKE;
               cnt_d   = '0;
            end
         end
         WAKE: begin
            if (cnt_q == CW'(WAKE_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Enable and wake pulse are registered from the next state so that
   // they line up with the state they describe.
   always_comb begin
      en_d   = (state_d != GATED);
      wd_d   = (state_q == WAKE) && (state_d == RUN);
      gcnt_d = gcnt_q;
      if (state_q == GATED && !(&gcnt_q)) begin
         gcnt_d = gcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
         en_q    <= 1'b1;
         wd_q    <= 1'b0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         wd_q    <= wd_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign clk_en_o    = en_q | force_en_i;
   assign sleep_ack_o = (state_q == GATED);
   assign sleeping_o  = (state_q == GATED) || (state_q == WAKE);
   assign wake_done_o = wd_q;
   assign gated_cnt_o = gcnt_q;

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Vector-table and scoreboard bench for cv32e40p_clock_gate_ctrl,
// plus a hand sequence for counter saturation and wake latency.
module tb_cv32e40p_clock_gate_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sreq, busy, wake, frc;
   logic en, ack, slp, wd;
   logic [31:0] gcnt;
   logic s_en, s_ack, s_slp, s_wd;
   logic [3:0] s_gcnt;

   cv32e40p_clock_gate_ctrl #(
      .IDLE_CYCLES(4), .WAKE_CYCLES(2), .STAT_W(32)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .sleep_req_i(sreq),
      .core_busy_i(busy), .wake_i(wake), .force_en_i(frc),
      .clk_en_o(en), .sleep_ack_o(ack), .sleeping_o(slp),
      .wake_done_o(wd), .gated_cnt_o(gcnt)
   );

   cv32e40p_clock_gate_ctrl #(
      .IDLE_CYCLES(4), .WAKE_CYCLES(2), .STAT_W(4)
   ) u_sat (
      .clk_i(clk), .rst_i(rst), .sleep_req_i(sreq),
      .core_busy_i(busy), .wake_i(wake), .force_en_i(frc),
      .clk_en_o(s_en), .sleep_ack_o(s_ack), .sleeping_o(s_slp),
      .wake_done_o(s_wd), .gated_cnt_o(s_gcnt)
   );

   typedef struct {
      logic        r, s, b, w, f;
      logic [3:0]  fl;
      logic [31:0] cnt;
   } vec_t;

   // flag order: {clk_en, sleep_ack, sleeping, wake_done}
   localparam logic [3:0] RN = 4'b1000;
   localparam logic [3:0] GT = 4'b0110;
   localparam logic [3:0] GF = 4'b1110;
   localparam logic [3:0] WK = 4'b1010;
   localparam logic [3:0] WD = 4'b1001;

   vec_t tbl[$];
   vec_t sbq[$];
   int nvec = 0;
   int nerr = 0;

   task automatic add(input int n, input logic r, s, b, w, f,
                      input logic [3:0] fl, input int cnt);
      vec_t v;
      v.r = r; v.s = s; v.b = b; v.w = w; v.f = f;
      v.fl = fl; v.cnt = cnt;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t e;
      logic ok;
      rst = 1'b1; sreq = 1'b0; busy = 1'b0; wake = 1'b0; frc = 1'b0;

      // normal sleep / wake
      add(1, 1,0,0,0,0, RN, 0);
      add(3, 0,0,0,0,0, RN, 0);
      add(4, 0,1,0,0,0, RN, 0);
      add(1, 0,1,0,0,0, GT, 0);
      for (int i = 1; i <= 5; i++) add(1, 0,1,0,0,0, GT, i);
      add(1, 0,1,0,1,0, WK, 6);
      add(1, 0,0,0,1,0, WK, 6);
      add(1, 0,0,0,0,0, WD, 6);
      add(1, 0,0,0,0,0, RN, 6);
      // busy restarts drain
      add(3, 0,1,0,0,0, RN, 6);
      add(1, 0,1,1,0,0, RN, 6);
      add(3, 0,1,0,0,0, RN, 6);
      add(1, 0,1,0,0,0, GT, 6);
      add(2, 0,0,0,0,0, WK, 7);
      add(1, 0,0,0,0,0, WD, 7);
      add(1, 0,0,0,0,0, RN, 7);
      // abort by wake in drain, then sleep+wake together in run
      add(2, 0,1,0,0,0, RN, 7);
      add(1, 0,1,0,1,0, RN, 7);
      add(3, 0,1,0,1,0, RN, 7);
      add(1, 0,0,0,0,0, RN, 7);
      // reset while gated
      add(4, 0,1,0,0,0, RN, 7);
      add(1, 0,1,0,0,0, GT, 7);
      add(1, 0,1,0,0,0, GT, 8);
      add(1, 0,1,0,0,0, GT, 9);
      add(1, 1,1,0,0,0, RN, 0);
      add(1, 0,0,0,0,0, RN, 0);
      // force override through a full sleep
      add(4, 0,1,0,0,1, RN, 0);
      add(1, 0,1,0,0,1, GF, 0);
      add(1, 0,1,0,0,1, GF, 1);
      add(1, 0,1,0,1,1, WK, 2);
      add(1, 0,0,0,0,1, WK, 2);
      add(1, 0,0,0,0,1, WD, 2);
      add(1, 0,0,0,0,0, RN, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].r; sreq = tbl[i].s; busy = tbl[i].b;
         wake = tbl[i].w; frc = tbl[i].f;
         sbq.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         chk($sformatf("vec%0d_flags", i),
             {28'd0, en, ack, slp, wd}, {28'd0, e.fl});
         chk($sformatf("vec%0d_gcnt", i), gcnt, e.cnt);
      end

      // saturation of a 4-bit statistics counter
      @(negedge clk);
      rst = 1'b1; sreq = 1'b0; busy = 1'b0; wake = 1'b0; frc = 1'b0;
      @(negedge clk);
      rst = 1'b0; sreq = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (s_ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk("sat_ack_seen", {31'd0, ok}, 32'd1);
      chk("sat_first_cnt", {28'd0, s_gcnt}, 32'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("sat_cnt_15", {28'd0, s_gcnt}, 32'd15);
      chk("wide_cnt_20", gcnt, 32'd20);
      chk("sat_clk_off", {31'd0, s_en}, 32'd0);

      // wake latency from gated
      @(negedge clk);
      wake = 1'b1;
      @(posedge clk);
      #1;
      chk("wake_en_g1", {31'd0, en}, 32'd1);
      chk("wake_ack_g1", {31'd0, ack}, 32'd0);
      @(negedge clk);
      sreq = 1'b0; wake = 1'b0;
      @(posedge clk);
      #1;
      chk("wake_wd_g2", {31'd0, wd}, 32'd0);
      chk("wake_slp_g2", {31'd0, slp}, 32'd1);
      @(posedge clk);
      #1;
      chk("wake_wd_g3", {31'd0, wd}, 32'd1);
      chk("wake_slp_g3", {31'd0, slp}, 32'd0);
      chk("sat_hold", {28'd0, s_gcnt}, 32'd15);
      @(posedge clk);
      #1;
      chk("wake_wd_g4", {31'd0, wd}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
